mousetrap_sync_src: RTL and testbench

Clocked source that launches words into a two-phase MOUSETRAP pipeline. It takes a synchronous valid/ready stream and converts each accepted word into one bundled-data transition on `req_out`, with `data_out` held stable across the event. It then waits for the matching transition on `ack_in`, which is first passed through a synchronizer. The block sits directly upstream of the first pipeline stage: `req_out`/`data_out` drive that stage's `reqN`/`datain`, and its `ackNm1` drives `ack_in`.

---
 rtl/mousetrap_sync_src.sv | 168 ++++++++++++++++
 tb/tb_mousetrap_sync_src.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mousetrap_sync_src.sv
// mousetrap_sync_src
//   Clocked source for a two-phase MOUSETRAP pipeline. Each word accepted from
//   a valid/ready stream is registered onto data_out. After REQ_DELAY extra
//   cycles of bundling margin, req_out toggles once. The block then waits for
//   the matching ack_in transition, which arrives through a SYNC_STAGES-deep
//   synchronizer.
//
//   Optional build macro: MOUSETRAP_SRC_SKID_EN adds a one-entry holding
//   register. With it, a word can be accepted while another is in flight.
//
// Parameters
//   WIDTH        data width (must match the first pipeline stage)
//   REQ_DELAY    extra cycles data_out is stable before req_out toggles (0..15)
//   SYNC_STAGES  flops in the ack_in synchronizer (>= 2)
//
// Ports
//   clk        single clock
//   rst        synchronous reset, active-high
//   in_valid   upstream word available
//   in_ready   word accepted on this edge when in_valid is also high
//   in_data    upstream word
//   req_out    two-phase request, one toggle per word
//   data_out   bundled data, registered
//   ack_in     two-phase acknowledge from the pipeline (asynchronous)
//   busy       a word is in flight
//   proto_err  sticky; the acknowledge toggled while none was expected
module mousetrap_sync_src #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned REQ_DELAY   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam logic [3:0] DELAY_LOAD = 4'(REQ_DELAY);

    state_t                 state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic [WIDTH-1:0]       data_nxt;
    logic                   req_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s, ack_s_nxt;
    logic                   accept, ack_done, ack_chg, err_pend;

    // ack_s is the synchronizer output. ack_s_nxt is the value ack_s takes on
    // the coming edge. Completion is decided from ack_s_nxt, so the FSM
    // leaves WAIT_ACK on the same edge the acknowledge lands in ack_s.
    assign ack_s     = sync[SYNC_STAGES-1];
    assign ack_s_nxt = sync[SYNC_STAGES-2];
    assign accept    = in_valid && in_ready;
    assign ack_done  = (state == WAIT_ACK) && (ack_s_nxt == req_out);
    // The state is sampled on the edge where ack_s changes. The sticky flag
    // is raised one edge later through err_pend.
    assign ack_chg   = (ack_s_nxt != ack_s) && (state != WAIT_ACK);
    assign busy      = (state != IDLE);

`ifdef MOUSETRAP_SRC_SKID_EN
    logic             skid_full, skid_full_nxt;
    logic [WIDTH-1:0] skid_data, skid_data_nxt;

    assign in_ready = !skid_full && !rst;
`else
    assign in_ready = (state == IDLE) && !rst;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_out;
        req_nxt   = req_out;
`ifdef MOUSETRAP_SRC_SKID_EN
        skid_full_nxt = skid_full;
        skid_data_nxt = skid_data;
        // Outside IDLE, an accepted word is parked in the skid. If the
        // handshake also completes on this edge, the WAIT_ACK branch below
        // routes the word straight to data_out instead.
        if (accept && (state != IDLE)) begin
            skid_full_nxt = 1'b1;
            skid_data_nxt = in_data;
        end
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    data_nxt  = in_data;
                    cnt_nxt   = DELAY_LOAD;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    req_nxt   = ~req_out;
                    state_nxt = WAIT_ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WAIT_ACK: begin
                if (ack_done) begin
`ifdef MOUSETRAP_SRC_SKID_EN
                    // Chain into the next word without passing through IDLE.
                    // The FSM never rests in IDLE with the skid full.
                    if (skid_full) begin
                        data_nxt      = skid_data;
                        skid_full_nxt = 1'b0;
                        cnt_nxt       = DELAY_LOAD;
                        state_nxt     = SETUP;
                    end else if (accept) begin
                        data_nxt      = in_data;
                        skid_full_nxt = 1'b0;
                        cnt_nxt       = DELAY_LOAD;
                        state_nxt     = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            data_out  <= '0;
            req_out   <= 1'b0;
            sync      <= '0;
            err_pend  <= 1'b0;
            proto_err <= 1'b0;
`ifdef MOUSETRAP_SRC_SKID_EN
            skid_full <= 1'b0;
            skid_data <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            data_out  <= data_nxt;
            req_out   <= req_nxt;
            sync      <= {sync[SYNC_STAGES-2:0], ack_in};
            err_pend  <= ack_chg;
            proto_err <= proto_err | err_pend;
`ifdef MOUSETRAP_SRC_SKID_EN
            skid_full <= skid_full_nxt;
            skid_data <= skid_data_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mousetrap_sync_src.sv
module tb_mousetrap_sync_src;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned REQ_DELAY   = 1;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef MOUSETRAP_SRC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic             ack_loop = 1'b1;
    logic             ack_man  = 1'b0;
    logic             in_ready, req_out, busy, proto_err, ack_in;
    logic [WIDTH-1:0] data_out;
    logic             d1, d2, d3;

    int tests_run    = 0;
    int tests_failed = 0;
    int toggles      = 0;
    logic req_prev   = 1'b0;

    mousetrap_sync_src #(
        .WIDTH      (WIDTH),
        .REQ_DELAY  (REQ_DELAY),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in),
        .busy     (busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Downstream stage model: ack follows req after three clocks, reset with the source.
    always @(posedge clk) begin
        if (rst) begin
            d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
        end else begin
            d1 <= req_out; d2 <= d1; d3 <= d2;
        end
    end
    assign ack_in = ack_loop ? d3 : ack_man;

    task automatic tick();
        @(posedge clk);
        #1;
        if (req_out !== req_prev) begin
            toggles++;
            req_prev = req_out;
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!busy) ok = 1'b1;
    endtask

    task automatic test_reset();
        bit static_ok;
        rst = 1'b1; in_valid = 1'b0; ack_loop = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({req_out, data_out, busy, proto_err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values: got req=%b data=%h busy=%b err=%b rdy=%b, expected all 0",
                     req_out, data_out, busy, proto_err, in_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
        static_ok = 1'b1;
        repeat (5) begin
            tick();
            if (req_out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) static_ok = 1'b0;
        end
        tests_run++;
        if (!static_ok) begin
            tests_failed++;
            $display("FAIL idle_static: got req=%b busy=%b rdy=%b expected 0/0/1", req_out, busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if (req_out !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre_reset: got req=%b busy=%b expected 1/1", req_out, busy);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({req_out, busy, in_ready, data_out} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL mid_reset_state: got req=%b busy=%b rdy=%b data=%h expected 0/0/0/00",
                     req_out, busy, in_ready, data_out);
        end
        rst = 1'b0;
        #1;
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (data_out !== 8'h3C || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_next_capture: got data=%h busy=%b expected 3c/1", data_out, busy);
        end
        wait_idle(30, ok);
        tests_run++;
        if (!ok || req_out !== 1'b1 || proto_err !== 1'b0 || data_out !== 8'h3C) begin
            tests_failed++;
            $display("FAIL mid_next_done: got idle=%b req=%b err=%b data=%h expected 1/1/0/3c",
                     ok, req_out, proto_err, data_out);
        end
    endtask

    task automatic test_single();
        logic req0;
        int n;
        bit found;
        req0 = req_out;
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (data_out !== 8'hA5 || req_out !== req0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_capture: got data=%h req=%b busy=%b expected a5/%b/1",
                     data_out, req_out, busy, req0);
        end
        tick();
        tests_run++;
        if (req_out !== req0) begin
            tests_failed++;
            $display("FAIL single_req_early: got %b expected %b", req_out, req0);
        end
        tick();
        tests_run++;
        if (req_out !== ~req0) begin
            tests_failed++;
            $display("FAIL single_req_toggle: got %b expected %b", req_out, ~req0);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ack_in === req_out) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        tests_run++;
        if (!found || n != int'(SYNC_STAGES)) begin
            tests_failed++;
            $display("FAIL single_busy_fall: got ack_seen=%b edges=%0d expected 1/%0d", found, n, SYNC_STAGES);
        end
        tests_run++;
        if (data_out !== 8'hA5 || in_ready !== 1'b1 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: got data=%h rdy=%b err=%b expected a5/1/0", data_out, in_ready, proto_err);
        end
    endtask

    task automatic test_burst();
        int t0, n;
        bit stable_ok, timeout;
        logic req0;
        t0 = toggles; req0 = req_out;
        stable_ok = 1'b1; timeout = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            in_data = 8'(k); in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 10) begin
                tick();
                n++;
            end
            if (!in_ready) timeout = 1'b1;
            tick();
            if (SKID) in_valid = 1'b0;
            if (data_out !== 8'(k)) stable_ok = 1'b0;
            n = 0;
            while (busy && n < 30) begin
                tick();
                n++;
                if (busy && data_out !== 8'(k)) stable_ok = 1'b0;
            end
            if (busy) timeout = 1'b1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (timeout) begin
            tests_failed++;
            $display("FAIL burst_timeout: got timeout=1 expected 0");
        end
        tests_run++;
        if (!stable_ok) begin
            tests_failed++;
            $display("FAIL burst_data_stable: got unstable data_out expected stable per word");
        end
        tests_run++;
        if (toggles - t0 != 8 || req_out !== req0) begin
            tests_failed++;
            $display("FAIL burst_toggles: got %0d req=%b expected 8 req=%b", toggles - t0, req_out, req0);
        end
        tests_run++;
        if (proto_err !== 1'b0 || data_out !== 8'h08) begin
            tests_failed++;
            $display("FAIL burst_end: got err=%b data=%h expected 0/08", proto_err, data_out);
        end
    endtask

    task automatic test_spurious();
        logic req0;
        req0 = req_out;
        ack_man = ack_in;
        ack_loop = 1'b0;
        tick(); tick();
        tests_run++;
        if (proto_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL spur_baseline: got err=%b busy=%b expected 0/0", proto_err, busy);
        end
        ack_man = ~ack_man;
        repeat (SYNC_STAGES + 1) tick();
        tests_run++;
        if (proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL spur_detect: got %b expected 1", proto_err);
        end
        ack_man = ~ack_man;
        repeat (6) tick();
        tests_run++;
        if (proto_err !== 1'b1 || busy !== 1'b0 || req_out !== req0) begin
            tests_failed++;
            $display("FAIL spur_sticky: got err=%b busy=%b req=%b expected 1/0/%b", proto_err, busy, req_out, req0);
        end
        ack_man = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL spur_clear: got %b expected 0", proto_err);
        end
        ack_loop = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t0;
`ifdef MOUSETRAP_SRC_SKID_EN
        logic req0;
        int ack_at, chg_at;
        bit idle_seen;
        t0 = toggles; req0 = req_out;
        in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        tests_run++;
        if (data_out !== 8'h11 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_first: got data=%h rdy=%b expected 11/1", data_out, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (data_out !== 8'h11 || in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_second: got data=%h rdy=%b busy=%b expected 11/0/1", data_out, in_ready, busy);
        end
        ack_at = -1; chg_at = -1; idle_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ack_at < 0 && ack_in !== req0) ack_at = i;
            if (!busy) idle_seen = 1'b1;
            if (data_out !== 8'h11) begin
                chg_at = i;
                break;
            end
        end
        tests_run++;
        if (chg_at < 0 || ack_at < 0 || data_out !== 8'h22 || idle_seen || chg_at - ack_at != int'(SYNC_STAGES)) begin
            tests_failed++;
            $display("FAIL skid_chain: got data=%h idle=%b lag=%0d expected 22/0/%0d",
                     data_out, idle_seen, chg_at - ack_at, SYNC_STAGES);
        end
        wait_idle(30, ok);
        tests_run++;
        if (!ok || toggles - t0 != 2 || proto_err !== 1'b0 || data_out !== 8'h22) begin
            tests_failed++;
            $display("FAIL skid_end: got idle=%b toggles=%0d err=%b data=%h expected 1/2/0/22",
                     ok, toggles - t0, proto_err, data_out);
        end
`else
        bit stable_ok;
        t0 = toggles;
        in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        tests_run++;
        if (data_out !== 8'h11 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_stall: got data=%h rdy=%b expected 11/0", data_out, in_ready);
        end
        stable_ok = 1'b1;
        for (int i = 0; i < 30 && busy; i++) begin
            tick();
            if (busy && data_out !== 8'h11) stable_ok = 1'b0;
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (!stable_ok || data_out !== 8'h22 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got stable=%b data=%h busy=%b expected 1/22/1", stable_ok, data_out, busy);
        end
        wait_idle(30, ok);
        tests_run++;
        if (!ok || toggles - t0 != 2 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: got idle=%b toggles=%0d err=%b expected 1/2/0", ok, toggles - t0, proto_err);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_burst();
        test_spurious();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
